// File: rtl/conv2x2_window_gen.sv
// conv2x2_window_gen
//
// Turns a raster-order 8-bit pixel stream into every 2x2 sliding window
// (stride 1, no padding) of an IMG_W x IMG_H frame. One image row plus one
// pixel is held in a shift-register line buffer. Each window leaves through
// a single 32-bit output register with a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   pix_in       pixel data (unsigned, 8 bits)
//   pix_valid    pixel present on pix_in
//   pix_ready    stage can accept a pixel this cycle (combinational)
//   frame_start  synchronous restart of the row/col position counters
//   win_out      packed window: [7:0] TL, [15:8] TR, [23:16] BL, [31:24] BR
//   win_valid    win_out holds an unconsumed window
//   win_ready    downstream accepts win_out this cycle
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted

module conv2x2_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        frame_start,
    output logic [31:0] win_out,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        frame_done
);

    localparam int CW = 6;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

    logic [7:0]    sr [0:IMG_W];
    logic [CW-1:0] col;
    logic [CW-1:0] row;

    logic          accept;
    logic [CW-1:0] col_eff;
    logic [CW-1:0] row_eff;
    logic          at_last_col;
    logic          at_last_row;
    logic          win_load;
    logic [31:0]   win_next;

    // Backpressure is applied to every pixel, not only window-completing
    // ones, so the line buffer can never slip relative to the output.
    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;

    // frame_start overrides the stored position before this cycle's accept
    // is applied, so a pixel accepted alongside it is (0,0).
    assign col_eff = frame_start ? '0 : col;
    assign row_eff = frame_start ? '0 : row;

    assign at_last_col = (col_eff == COL_LAST);
    assign at_last_row = (row_eff == ROW_LAST);

    // col==0 windows would straddle two rows, so they are skipped.
    assign win_load = accept && (row_eff != '0) && (col_eff != '0);

    assign win_next = {pix_in, sr[0], sr[IMG_W-1], sr[IMG_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= IMG_W; k++) begin
                sr[k] <= '0;
            end
        end else if (accept) begin
            sr[0] <= pix_in;
            for (int k = 1; k <= IMG_W; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (at_last_col) begin
                col <= '0;
                row <= at_last_row ? '0 : row_eff + 1'b1;
            end else begin
                col <= col_eff + 1'b1;
                row <= row_eff;
            end
        end else begin
            col <= col_eff;
            row <= row_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && at_last_col && at_last_row;
        end
    end

    // A load in the same cycle as a consume replaces the window and keeps
    // win_valid high, giving full throughput with win_ready held high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_out   <= '0;
            win_valid <= 1'b0;
        end else if (win_load) begin
            win_out   <= win_next;
            win_valid <= 1'b1;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv2x2_window_gen.sv
module tb_conv2x2_window_gen;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_start;
    logic [31:0] win_out;
    logic        win_valid;
    logic        win_ready;
    logic        frame_done;

    conv2x2_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .frame_start (frame_start),
        .win_out     (win_out),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_win    = 0;
    int n_fd     = 0;
    logic [31:0] exp_q [$];

    logic [31:0] basic_tbl [6] = '{32'h06050201, 32'h07060302, 32'h08070403,
                                   32'h0A090605, 32'h0B0A0706, 32'h0C0B0807};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Expected window for the pixel at (r,c) of a frame whose (0,0) pixel is p0.
    function automatic logic [31:0] win_of(input int p0, input int r, input int c);
        int br;
        br = p0 + r * W + c;
        return {8'(br), 8'(br - 1), 8'(br - W), 8'(br - W - 1)};
    endfunction

    // Monitor: pops and compares whenever a window is handed over.
    always @(negedge clk) begin
        if (rst_n && win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_window: got %h expected none", win_out);
            end else begin
                check("window", win_out, exp_q.pop_front());
            end
            n_win++;
        end
        if (frame_done) n_fd++;
    end

    task automatic send(input logic [7:0] p, input logic fs, input logic has_win,
                        input logic [31:0] w);
        int  budget;
        logic acc;
        if (has_win) exp_q.push_back(w);
        pix_in      = p;
        pix_valid   = 1'b1;
        frame_start = fs;
        budget      = 50;
        acc         = 1'b0;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = pix_ready;
            if (!acc) begin
                @(posedge clk);
                #1;
                budget--;
            end
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout: pixel %h never accepted, expected accept", p);
        end
        @(posedge clk);
        #1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        pix_in    = 8'hEE;
        @(posedge clk);
        #1;
    endtask

    // Three-cycle stall with the first window pending; the next pixel is
    // presented throughout and must be refused.
    task automatic stall(input logic [7:0] p);
        win_ready = 1'b0;
        pix_in    = p;
        pix_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("bp_pix_ready", {31'd0, pix_ready}, 32'd0);
            check("bp_win_out", win_out, 32'h06050201);
            check("bp_win_valid", {31'd0, win_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        win_ready = 1'b1;
    endtask

    task automatic send_frame(input int p0, input bit fs_first, input bit gap,
                              input bit use_tbl, input int stall_at);
        int k;
        int r;
        int c;
        logic hw;
        logic [31:0] w;
        k = 0;
        for (int i = 0; i < W * H; i++) begin
            r  = i / W;
            c  = i % W;
            hw = (r >= 1) && (c >= 1);
            w  = use_tbl ? basic_tbl[k % 6] : win_of(p0, r, c);
            if (hw) k++;
            if (gap && $urandom_range(0, 1) == 1) idle();
            if (i == stall_at) stall(8'(p0 + i));
            send(8'(p0 + i), fs_first && (i == 0), hw, w);
        end
    endtask

    task automatic drain(input string name, input int exp_win, input int exp_fd);
        int budget;
        budget = 30;
        while ((exp_q.size() != 0 || win_valid) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            $display("FAIL %s_drain: %0d windows outstanding, expected 0", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_win_count"}, 32'(n_win), 32'(exp_win));
        check({name, "_fd_count"}, 32'(n_fd), 32'(exp_fd));
        exp_q.delete();
        n_win = 0;
        n_fd  = 0;
    endtask

    initial begin
        rst_n       = 1'b0;
        pix_in      = 8'h00;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        win_ready   = 1'b1;
        #1;
        check("rst_win_valid", {31'd0, win_valid}, 32'd0);
        check("rst_win_out", win_out, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_pix_ready", {31'd0, pix_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame, plus frame_done timing.
        send_frame(1, 1'b0, 1'b0, 1'b1, -1);
        check("basic_fd_high", {31'd0, frame_done}, 32'd1);
        @(posedge clk);
        #1;
        check("basic_fd_low", {31'd0, frame_done}, 32'd0);
        drain("basic", 6, 1);

        // Backpressure on the first window.
        send_frame(1, 1'b0, 1'b0, 1'b1, 6);
        drain("bp", 6, 1);

        // Gapped input.
        send_frame(1, 1'b0, 1'b1, 1'b1, -1);
        drain("gap", 6, 1);

        // Back-to-back frames.
        send_frame(1, 1'b0, 1'b0, 1'b0, -1);
        send_frame(13, 1'b0, 1'b0, 1'b0, -1);
        drain("b2b", 12, 2);

        // Mid-frame restart: pixel 100 becomes (0,0).
        for (int i = 0; i < 6; i++) begin
            send(8'(1 + i), 1'b0, (i == 5), 32'h06050201);
        end
        send_frame(100, 1'b1, 1'b0, 1'b0, -1);
        drain("restart", 7, 1);

        // Async reset with a window pending.
        win_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(8'(1 + i), 1'b0, 1'b0, 32'd0);
        end
        check("pre_rst_win_valid", {31'd0, win_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_win_valid", {31'd0, win_valid}, 32'd0);
        check("arst_win_out", win_out, 32'd0);
        check("arst_frame_done", {31'd0, frame_done}, 32'd0);
        check("arst_pix_ready", {31'd0, pix_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        win_ready = 1'b1;
        n_win     = 0;
        n_fd      = 0;
        @(posedge clk);
        #1;
        send_frame(1, 1'b0, 1'b0, 1'b1, -1);
        drain("post_rst", 6, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
